// File: rtl/terminal_row_reader_pkg.sv
// Shared terminal constants and the cell address helper used by the row reader
// and the stream writer.
package terminal_row_reader_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Row stride in cells: each row occupies 128 cell slots in SDRAM.
    localparam int unsigned REAL_WIDTH = 128;

    // Byte address of the cell at (x, y): 4-byte cells, 128-cell row stride.
    function automatic logic [22:0] address_from_position(input logic [6:0] x,
                                                          input logic [5:0] y);
        return {8'b0, y, x, 2'b00};
    endfunction

endpackage

// File: rtl/terminal_row_reader_row_buffer.sv
// Ping-pong line buffer: simple dual-port RAM holding two rows of COLUMNS cells.
// Bank select chooses the half; the read output is registered and returns zero
// for indices past the end of the row.
module terminal_row_reader_row_buffer #(
    parameter int unsigned COLUMNS = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        wr_bank,
    input  logic [6:0]  wr_index,
    input  logic [31:0] wr_data,
    input  logic        rd_bank,
    input  logic [6:0]  rd_index,
    output logic [31:0] rd_data
);

    localparam int unsigned DEPTH = 2 * COLUMNS;

    logic [31:0] mem [DEPTH];
    logic [7:0]  wr_addr;
    logic [7:0]  rd_addr;
    logic        rd_in_row;

    // Flatten {bank, index} into the packed 2*COLUMNS address space.
    always_comb begin
        wr_addr   = {1'b0, wr_index} + (wr_bank ? 8'(COLUMNS) : 8'd0);
        rd_addr   = {1'b0, rd_index} + (rd_bank ? 8'(COLUMNS) : 8'd0);
        rd_in_row = ({25'd0, rd_index} < COLUMNS);
    end

    // Write port; the memory array itself is not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 32'h0;
        end else begin
            rd_data <= rd_in_row ? mem[rd_addr] : 32'h0;
        end
    end

endmodule

// File: rtl/terminal_row_reader.sv
// Fetches one text row from SDRAM with a single burst into the back half of a
// ping-pong line buffer while the character generator reads the front half.
// Optional feature: define TERMINAL_ROW_READER_STATS_EN to add underrun_count.
module terminal_row_reader
    import terminal_row_reader_pkg::*;
#(
    parameter int unsigned COLUMNS = 80,
    parameter int unsigned ROWS    = 51
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_row,
    input  logic [5:0]  fetch_y,
    input  logic        swap,
    input  logic [6:0]  cell_x,
    output logic [31:0] cell_data,
    output logic        busy,
    output logic        back_ready,
    output logic        underrun,
    output logic        overrun,
`ifdef TERMINAL_ROW_READER_STATS_EN
    output logic [15:0] underrun_count,
`endif
    output logic [22:0] rd_address,
    output logic        rd_request,
    output logic [8:0]  rd_burst_length,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    input  logic        rd_done
);

    typedef enum logic [0:0] {
        STAGE_IDLE    = 1'b0,
        STAGE_RECEIVE = 1'b1
    } stage_t;

    stage_t      stage_q, stage_d;
    logic [7:0]  index_q, index_d;
    logic        front_q, front_d;
    logic        busy_q, busy_d;
    logic        back_ready_q, back_ready_d;
    logic        underrun_q, underrun_d;
    logic        overrun_q, overrun_d;
    logic        rd_request_q, rd_request_d;
    logic [22:0] rd_address_q, rd_address_d;

    logic        wr_en;
    logic [7:0]  final_index;
    logic        completing;
    logic [5:0]  y_eff;

    // Next-state: burst reception first, then swap, then a new fetch request.
    always_comb begin
        stage_d      = stage_q;
        index_d      = index_q;
        front_d      = front_q;
        busy_d       = busy_q;
        back_ready_d = back_ready_q;
        underrun_d   = FALSE;
        overrun_d    = FALSE;
        rd_request_d = FALSE;
        rd_address_d = rd_address_q;
        wr_en        = FALSE;
        final_index  = index_q;
        completing   = FALSE;
        y_eff        = ({26'd0, fetch_y} >= ROWS) ? 6'd0 : fetch_y;

        if (stage_q == STAGE_RECEIVE) begin
            // Words past the end of the row are dropped.
            if (rd_data_valid && ({24'd0, index_q} < COLUMNS)) begin
                wr_en       = !reset;
                final_index = index_q + 8'd1;
            end
            index_d = final_index;
            if (rd_done) begin
                busy_d  = FALSE;
                stage_d = STAGE_IDLE;
                if ({24'd0, final_index} == COLUMNS) begin
                    back_ready_d = TRUE;
                    completing   = TRUE;
                end
            end
        end

        // A swap landing on the completing cycle sees the freshly finished row.
        if (swap) begin
            if (back_ready_q || completing) begin
                front_d      = ~front_q;
                back_ready_d = FALSE;
            end else begin
                underrun_d = TRUE;
            end
        end

        if (fetch_row) begin
            if (stage_q == STAGE_IDLE) begin
                rd_address_d = address_from_position(7'd0, y_eff);
                rd_request_d = TRUE;
                busy_d       = TRUE;
                back_ready_d = FALSE;
                index_d      = 8'd0;
                stage_d      = STAGE_RECEIVE;
            end else begin
                overrun_d = TRUE;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q      <= STAGE_IDLE;
            index_q      <= 8'd0;
            front_q      <= FALSE;
            busy_q       <= FALSE;
            back_ready_q <= FALSE;
            underrun_q   <= FALSE;
            overrun_q    <= FALSE;
            rd_request_q <= FALSE;
            rd_address_q <= 23'd0;
        end else begin
            stage_q      <= stage_d;
            index_q      <= index_d;
            front_q      <= front_d;
            busy_q       <= busy_d;
            back_ready_q <= back_ready_d;
            underrun_q   <= underrun_d;
            overrun_q    <= overrun_d;
            rd_request_q <= rd_request_d;
            rd_address_q <= rd_address_d;
        end
    end

`ifdef TERMINAL_ROW_READER_STATS_EN
    logic [15:0] underrun_count_q;

    // Saturating count of underrun pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_count_q <= 16'd0;
        end else if (underrun_d && (underrun_count_q != 16'hFFFF)) begin
            underrun_count_q <= underrun_count_q + 16'd1;
        end
    end

    assign underrun_count = underrun_count_q;
`endif

    // Writes go to the back half, reads come from the front half.
    terminal_row_reader_row_buffer #(
        .COLUMNS (COLUMNS)
    ) u_row_buffer (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_bank  (~front_q),
        .wr_index (index_q[6:0]),
        .wr_data  (rd_data),
        .rd_bank  (front_q),
        .rd_index (cell_x),
        .rd_data  (cell_data)
    );

    assign busy            = busy_q;
    assign back_ready      = back_ready_q;
    assign underrun        = underrun_q;
    assign overrun         = overrun_q;
    assign rd_request      = rd_request_q;
    assign rd_address      = rd_address_q;
    assign rd_burst_length = 9'(COLUMNS);

endmodule

// File: tb/tb_terminal_row_reader.sv
// Self-checking bench for terminal_row_reader: a row-level model of the line
// buffer checked every cycle, plus directed checks with hand-computed values.
module tb_terminal_row_reader;

    localparam int COLS = 80;
    localparam int NROWS = 51;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_row = 1'b0;
    logic [5:0]  fetch_y = 6'd0;
    logic        swap = 1'b0;
    logic [6:0]  cell_x = 7'd0;
    logic [31:0] cell_data;
    logic        busy, back_ready, underrun, overrun;
    logic [22:0] rd_address;
    logic        rd_request;
    logic [8:0]  rd_burst_length;
    logic [31:0] rd_data = 32'd0;
    logic        rd_data_valid = 1'b0;
    logic        rd_done = 1'b0;
`ifdef TERMINAL_ROW_READER_STATS_EN
    logic [15:0] underrun_count;
`endif

    int n_checks = 0;
    int n_fail = 0;

    terminal_row_reader #(
        .COLUMNS (COLS),
        .ROWS    (NROWS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_row       (fetch_row),
        .fetch_y         (fetch_y),
        .swap            (swap),
        .cell_x          (cell_x),
        .cell_data       (cell_data),
        .busy            (busy),
        .back_ready      (back_ready),
        .underrun        (underrun),
        .overrun         (overrun),
`ifdef TERMINAL_ROW_READER_STATS_EN
        .underrun_count  (underrun_count),
`endif
        .rd_address      (rd_address),
        .rd_request      (rd_request),
        .rd_burst_length (rd_burst_length),
        .rd_data         (rd_data),
        .rd_data_valid   (rd_data_valid),
        .rd_done         (rd_done)
    );

    always #5 clk = ~clk;

    // ---------------- model: two row halves plus flags ----------------
    logic [31:0] m_row [2][128];
    bit          m_known [2][128];
    int          m_front = 0;
    int          m_count = 0;
    bit          m_busy = 0, m_ready = 0, m_under = 0, m_over = 0, m_req = 0;
    logic [22:0] m_addr = 23'd0;
    logic [31:0] m_cell = 32'd0;
    bit          m_cell_known = 1;
    int          m_ucount = 0;

    task automatic model_step();
        bit was_busy, done_row;
        int y;
        if (reset) begin
            m_front = 0; m_count = 0; m_busy = 0; m_ready = 0;
            m_under = 0; m_over = 0; m_req = 0; m_addr = 23'd0;
            m_cell = 32'd0; m_cell_known = 1; m_ucount = 0;
            return;
        end
        // Read sees the front half as it was before this cycle's swap.
        if (int'(cell_x) < COLS) begin
            m_cell = m_row[m_front][cell_x];
            m_cell_known = m_known[m_front][cell_x];
        end else begin
            m_cell = 32'd0;
            m_cell_known = 1;
        end
        m_under = 0; m_over = 0; m_req = 0;
        was_busy = m_busy;
        done_row = 0;
        if (m_busy) begin
            if (rd_data_valid && m_count < COLS) begin
                m_row[1 - m_front][m_count] = rd_data;
                m_known[1 - m_front][m_count] = 1;
                m_count++;
            end
            if (rd_done) begin
                m_busy = 0;
                if (m_count == COLS) begin
                    m_ready = 1;
                    done_row = 1;
                end
            end
        end
        if (swap) begin
            if (m_ready) begin
                m_front = 1 - m_front;
                m_ready = 0;
            end else begin
                m_under = 1;
                if (m_ucount < 65535) m_ucount++;
            end
        end
        if (fetch_row) begin
            if (!was_busy) begin
                y = (int'(fetch_y) >= NROWS) ? 0 : int'(fetch_y);
                m_addr = 23'(y * 128 * 4);
                m_req = 1; m_busy = 1; m_ready = 0; m_count = 0;
            end else begin
                m_over = 1;
            end
        end
        if (done_row && !m_ready) begin
            // row was consumed by a coincident swap; nothing else to record
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("busy", 32'(busy), 32'(m_busy));
            check("back_ready", 32'(back_ready), 32'(m_ready));
            check("underrun", 32'(underrun), 32'(m_under));
            check("overrun", 32'(overrun), 32'(m_over));
            check("rd_request", 32'(rd_request), 32'(m_req));
            check("rd_address", 32'(rd_address), 32'(m_addr));
            check("rd_burst_length", 32'(rd_burst_length), 32'(COLS));
            if (m_cell_known) check("cell_data", cell_data, m_cell);
`ifdef TERMINAL_ROW_READER_STATS_EN
            check("underrun_count", 32'(underrun_count), 32'(m_ucount));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [5:0] y);
        fetch_y = y;
        fetch_row = 1'b1;
        tick();
        fetch_row = 1'b0;
    endtask

    task automatic do_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    task automatic feed(input int n, input logic [31:0] base, input bit done_last,
                        input bit swap_last);
        for (int k = 0; k < n; k++) begin
            rd_data = base + 32'(k);
            rd_data_valid = 1'b1;
            rd_done = done_last && (k == n - 1);
            swap = swap_last && (k == n - 1);
            tick();
        end
        rd_data_valid = 1'b0;
        rd_done = 1'b0;
        swap = 1'b0;
    endtask

    task automatic read_cell(input logic [6:0] x, input logic [31:0] exp, input string name);
        cell_x = x;
        tick();
        check(name, cell_data, exp);
    endtask

    initial begin
        repeat (3) tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset back_ready", 32'(back_ready), 32'd0);
        check("reset cell_data", cell_data, 32'd0);
        check("reset rd_request", 32'(rd_request), 32'd0);
        check("reset burst_len", 32'(rd_burst_length), 32'd80);
        reset = 1'b0;
        tick();

        // Row 3: address, single-cycle request, full burst of k.
        do_fetch(6'd3);
        check("fetch3 rd_request", 32'(rd_request), 32'd1);
        check("fetch3 rd_address", 32'(rd_address), 32'h000600);
        check("fetch3 busy", 32'(busy), 32'd1);
        tick();
        check("fetch3 req pulse", 32'(rd_request), 32'd0);
        feed(80, 32'd0, 1, 0);
        check("row3 back_ready", 32'(back_ready), 32'd1);
        check("row3 busy", 32'(busy), 32'd0);

        do_swap();
        check("swap clears ready", 32'(back_ready), 32'd0);
        for (int i = 0; i < 80; i++) read_cell(7'(i), 32'(i), "row3 cell");
        read_cell(7'd100, 32'h0, "cell_x 100");

        // Swap with nothing ready: underrun, front unchanged.
        cell_x = 7'd5;
        do_swap();
        check("underrun pulse", 32'(underrun), 32'd1);
        check("old front kept", cell_data, 32'd5);
        tick();
        check("underrun single", 32'(underrun), 32'd0);

        // Fetch during receive is dropped with an overrun pulse.
        do_fetch(6'd10);
        tick();
        feed(20, 32'hA000_0000, 0, 0);
        rd_data = 32'hA000_0014;
        rd_data_valid = 1'b1;
        fetch_y = 6'd20;
        fetch_row = 1'b1;
        tick();
        fetch_row = 1'b0;
        check("overrun pulse", 32'(overrun), 32'd1);
        check("no second request", 32'(rd_request), 32'd0);
        check("overrun addr kept", 32'(rd_address), 32'h001400);
        feed(59, 32'hA000_0015, 1, 0);
        check("row10 back_ready", 32'(back_ready), 32'd1);
        do_swap();
        read_cell(7'd20, 32'hA000_0014, "row10 cell20");
        read_cell(7'd79, 32'hA000_004F, "row10 cell79");

        // Out-of-range row maps to 0; extra words dropped.
        do_fetch(6'd60);
        check("y60 rd_address", 32'(rd_address), 32'h0);
        feed(85, 32'hB000_0000, 1, 0);
        check("long burst ready", 32'(back_ready), 32'd1);
        do_swap();
        read_cell(7'd79, 32'hB000_004F, "long burst cell79");

        // Short burst never becomes ready.
        do_fetch(6'd2);
        feed(70, 32'hC000_0000, 1, 0);
        check("short back_ready", 32'(back_ready), 32'd0);
        check("short busy", 32'(busy), 32'd0);
        do_swap();
        check("short swap underrun", 32'(underrun), 32'd1);
        read_cell(7'd10, 32'hB000_000A, "front after short");

        // Swap coinciding with the completing rd_done is honoured.
        do_fetch(6'd1);
        feed(80, 32'hD000_0000, 1, 1);
        check("coincident underrun", 32'(underrun), 32'd0);
        check("coincident ready", 32'(back_ready), 32'd0);
        read_cell(7'd3, 32'hD000_0003, "coincident cell3");

        // Fetch and swap in the same idle cycle: swap first, fetch into new back.
        do_fetch(6'd4);
        feed(80, 32'hE000_0000, 1, 0);
        fetch_y = 6'd5;
        fetch_row = 1'b1;
        swap = 1'b1;
        tick();
        fetch_row = 1'b0;
        swap = 1'b0;
        check("fetch+swap underrun", 32'(underrun), 32'd0);
        check("fetch+swap address", 32'(rd_address), 32'h000A00);
        read_cell(7'd7, 32'hE000_0007, "fetch+swap front");
        feed(80, 32'hF000_0000, 1, 0);
        read_cell(7'd8, 32'hE000_0008, "front intact");
        do_swap();
        read_cell(7'd0, 32'hF000_0000, "new front cell0");

        // Reset mid-burst.
        do_fetch(6'd6);
        feed(40, 32'h9000_0000, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset ready", 32'(back_ready), 32'd0);
        feed(40, 32'h9000_0028, 1, 0);
        check("leftover ignored", 32'(back_ready), 32'd0);
        check("leftover busy", 32'(busy), 32'd0);
`ifdef TERMINAL_ROW_READER_STATS_EN
        check("count after reset", 32'(underrun_count), 32'd0);
`endif
        repeat (3) begin
            do_swap();
            check("post reset underrun", 32'(underrun), 32'd1);
            tick();
        end
`ifdef TERMINAL_ROW_READER_STATS_EN
        check("underrun_count 3", 32'(underrun_count), 32'd3);
`endif
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
